odd_check: RTL and testbench

ODD_CHECK -- requirements
Module: odd_check

---
 rtl/odd_check.sv | 82 ++++++++
 tb/tb_odd_check.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/odd_check.sv
// Odd-parity generator plus a registered parity checker with a sticky error flag.
// Define ODD_CHECK_ERR_CNT_EN to add the saturating err_cnt error counter and its port.
module odd_check #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     din,
    output logic             dout,
    input  logic             in_valid,
    input  logic             par_in,
    input  logic             clr,
    output logic             out_valid,
    output logic             dout_q,
    output logic             err,
    output logic             err_sticky
`ifdef ODD_CHECK_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    logic valid_q, valid_d;
    logic par_q, par_d;
    logic err_q, err_d;
    logic sticky_q, sticky_d;

    // The reduction is left unmasked so X/Z bits on din show up as X on dout.
    assign dout = ~^din;

    always_comb begin
        valid_d  = in_valid;
        par_d    = in_valid ? ~^din : par_q;
        err_d    = in_valid & ~(^din ^ par_in);
        sticky_d = clr ? 1'b0 : (sticky_q | err_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            par_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            par_q    <= par_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = valid_q;
    assign dout_q     = par_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

`ifdef ODD_CHECK_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clr beats a concurrent error; the counter holds at its ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (err_d && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_odd_check.sv
// Randomized self-checking bench for odd_check against a countones-based reference model.
// Checks err_cnt only when ODD_CHECK_ERR_CNT_EN is defined.
module tb_odd_check;

    localparam int N     = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, in_valid, par_in, clr;
    logic [N-1:0]     din;
    logic             dout, out_valid, dout_q, err, err_sticky;
`ifdef ODD_CHECK_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       cnt2, cnt4, cnt6;
`endif

    logic [1:0] din2;
    logic [3:0] din4;
    logic [5:0] din6;
    logic       dout2, dout4, dout6;
    logic [3:0] ov_n, dq_n, er_n, st_n;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_valid, m_dout_q, m_err, m_sticky, m_cnt;

    always #5 clk = ~clk;

    odd_check #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .in_valid(in_valid),
        .par_in(par_in), .clr(clr), .out_valid(out_valid), .dout_q(dout_q),
        .err(err), .err_sticky(err_sticky)
`ifdef ODD_CHECK_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    odd_check #(.N(2)) u_n2 (
        .clk(clk), .rst(1'b1), .din(din2), .dout(dout2), .in_valid(1'b0),
        .par_in(1'b0), .clr(1'b0), .out_valid(ov_n[0]), .dout_q(dq_n[0]),
        .err(er_n[0]), .err_sticky(st_n[0])
`ifdef ODD_CHECK_ERR_CNT_EN
        , .err_cnt(cnt2)
`endif
    );

    odd_check #(.N(4)) u_n4 (
        .clk(clk), .rst(1'b1), .din(din4), .dout(dout4), .in_valid(1'b0),
        .par_in(1'b0), .clr(1'b0), .out_valid(ov_n[1]), .dout_q(dq_n[1]),
        .err(er_n[1]), .err_sticky(st_n[1])
`ifdef ODD_CHECK_ERR_CNT_EN
        , .err_cnt(cnt4)
`endif
    );

    odd_check #(.N(6)) u_n6 (
        .clk(clk), .rst(1'b1), .din(din6), .dout(dout6), .in_valid(1'b0),
        .par_in(1'b0), .clr(1'b0), .out_valid(ov_n[2]), .dout_q(dq_n[2]),
        .err(er_n[2]), .err_sticky(st_n[2])
`ifdef ODD_CHECK_ERR_CNT_EN
        , .err_cnt(cnt6)
`endif
    );

    assign ov_n[3] = 1'b0;
    assign dq_n[3] = 1'b0;
    assign er_n[3] = 1'b0;
    assign st_n[3] = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Parity bit that makes the word's total count of ones odd.
    function automatic int odd_bit(input logic [63:0] v);
        return ($countones(v) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [N-1:0] d,
                       input logic p, input logic c);
        int ones;
        rst = r; in_valid = v; din = d; par_in = p; clr = c;
        #1;
        chk("dout", 64'(dout), 64'(odd_bit(64'(d))));
        ones = $countones(d);
        if (r) begin
            m_valid = 0; m_dout_q = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            m_valid = v;
            if (v) m_dout_q = odd_bit(64'(d));
            m_err = (v && ((ones + p) % 2 == 0)) ? 1 : 0;
            if (c) begin
                m_sticky = 0; m_cnt = 0;
            end else if (m_err == 1) begin
                m_sticky = 1;
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("dout_q", 64'(dout_q), 64'(m_dout_q));
        chk("err", 64'(err), 64'(m_err));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
`ifdef ODD_CHECK_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = '0; par_in = 1'b0; clr = 1'b0;
        din2 = '0; din4 = '0; din6 = '0;
        m_valid = 0; m_dout_q = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
        @(posedge clk);
        #1;

        // exhaustive combinational sweep on narrow widths, one value per 10 ns
        for (int i = 0; i < 64; i++) begin
            din2 = 2'(i); din4 = 4'(i); din6 = 6'(i);
            #1;
            if (i < 4)  chk("sweep_n2", 64'(dout2), 64'(odd_bit(64'(i % 4))));
            if (i < 16) chk("sweep_n4", 64'(dout4), 64'(odd_bit(64'(i % 16))));
            chk("sweep_n6", 64'(dout6), 64'(odd_bit(64'(i))));
            #9;
        end

        // reset state with an error word presented during reset
        cyc(1, 1, 8'h03, 0, 0);
        cyc(1, 0, 8'h00, 0, 0);

        // good word, then error word, then idle
        cyc(0, 1, 8'h03, 1, 0);
        cyc(0, 1, 8'h03, 0, 0);
        cyc(0, 0, 8'hFF, 0, 0);
        cyc(0, 0, 8'h01, 1, 0);

        // clear, then five error words to saturate, then clr with an error word
        cyc(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h03, 0, 0);
        cyc(0, 1, 8'h03, 0, 1);
        cyc(0, 1, 8'h7F, 0, 0);

        // reset mid-stream discards an error word
        cyc(1, 1, 8'h00, 0, 0);
        cyc(0, 1, 8'hA5, 1, 0);

        // boundary words
        cyc(0, 1, 8'h00, 1, 0);
        cyc(0, 1, 8'hFF, 0, 0);
        cyc(0, 1, 8'h80, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
                1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
